// File: rtl/argmax_stream.sv
// argmax_stream: groups every N signed elements into a vector
// and emits the index and value of its largest element.
module argmax_stream #(
  parameter int T  = 16,
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [IW-1:0]       idx_out
);

  logic [IW-1:0]       cnt;
  logic signed [T-1:0] best_val;
  logic [IW-1:0]       best_idx;
  logic signed [T-1:0] win_val;
  logic [IW-1:0]       win_idx;
  logic                last;
  logic                accept;

  assign last    = (cnt == IW'(N - 1));
  assign s_ready = !(last && m_valid && !m_ready);
  assign accept  = s_valid && s_ready;

  // winner including the element on data_in; ties keep lowest index
  always_comb begin
    win_val = best_val;
    win_idx = best_idx;
    if (cnt == '0) begin
      win_val = data_in;
      win_idx = '0;
    end else if (data_in > best_val) begin
      win_val = data_in;
      win_idx = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
      m_valid  <= 1'b0;
      data_out <= '0;
      idx_out  <= '0;
    end else begin
      if (accept) begin
        cnt      <= last ? '0 : cnt + 1'b1;
        best_val <= win_val;
        best_idx <= win_idx;
      end
      if (accept && last) begin
        data_out <= win_val;
        idx_out  <= win_idx;
        m_valid  <= 1'b1;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Streaming classifier stage that sits directly downstream of the generated network (e.g. network_4_8_12_16_30_16). It consumes the network's output stream of signed T-bit values, groups every N consecutive values into one output vector, and emits one result per vector: the index and value of the largest element. Both sides use the same valid/ready handshake as the network, so the block drops onto the network's m_valid/m_ready/data_out port unchanged.

## Interface
- T, default 16: element width, signed two's complement
- N, default 16: elements per vector (final layer size); N >= 2
- IW, default 4: index width; must satisfy 2^IW >= N
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream element valid
- s_ready  out  1  block accepts element this cycle
- data_in  in  T  signed element
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- data_out  out  T  signed max value of completed vector
- idx_out  out  IW  index (0..N-1) of max element within vector

## Operation
- Element accepted on a rising edge when s_valid && s_ready; result transferred when m_valid && m_ready.
- Element counter cnt (0..N-1) tracks position within current vector; increments per accepted element, wraps N-1 -> 0.
- Running registers best_val (T, signed) and best_idx (IW):
  - cnt == 0 on accept: best_val <= data_in, best_idx <= 0 unconditionally.
  - cnt > 0 on accept: update to (data_in, cnt) only if data_in > best_val, signed compare, strictly greater; ties keep lowest index.
- Completion: accept with cnt == N-1 loads the output register with the final winner, considering the element just accepted, and sets m_valid. Running registers become don't-care; the next accept has cnt == 0.
- Output register is held stable (data_out, idx_out, m_valid) while m_valid && !m_ready.
- m_valid clears on transfer unless a new completion occurs on the same edge, in which case the new result is loaded and m_valid stays 1.
- s_ready = !(cnt == N-1 && m_valid && !m_ready). Elements 0..N-2 of the next vector are accepted while a result waits. Only the last element stalls. s_ready has a combinational path from m_ready; there is no path from s_valid.
- No arithmetic beyond the compare; no saturation; values pass through bit-exact.

## Timing
- Reset values: cnt=0, m_valid=0, data_out=0, idx_out=0, best_val=0, best_idx=0. s_ready=1 in the cycle after reset.
- Reset mid-vector discards the partial vector and any pending result. The first accept after reset is element 0.
- Latency: last element accepted at edge k -> m_valid=1 with result in cycle after k (1 cycle).
- Throughput: one vector per N cycles at full rate, zero bubbles, when m_ready is held high.
- Simultaneous result transfer and completion at the same edge: no stall, new result visible next cycle.
- s_valid low: no state change. m_ready with m_valid low: ignored.

## Test plan
- Ascending vector 0,1,...,15 at full rate, m_ready=1 -> one result: data_out=0x000F, idx_out=15, m_valid for exactly 1 cycle, 1 cycle after the 16th accept.
- All sixteen elements = 0xFFFB (-5) -> data_out=0xFFFB, idx_out=0 (tie keeps lowest index). Vector with element 3 = 0x7FFF, element 9 = 0x8000, rest 0 -> 0x7FFF, idx 3. All negative with -1 at index 7 -> 0xFFFF, idx 7.
- Backpressure: m_ready=0 after the first result. The second vector's 15 elements are accepted, then s_ready=0 with cnt=15. The first result stays unchanged for 20 cycles. Raising m_ready -> the first result transfers and the 16th element is accepted on the same edge. The second result appears the next cycle.
- Reset asserted for 1 cycle after 7 elements are accepted -> m_valid=0, outputs 0. The next 16 elements (max 0x0042 at index 12) give idx_out=12, data_out=0x0042.
- Back-to-back vectors with m_ready=1 and s_valid=1 continuously for 4 vectors -> 4 results on cycles 16, 32, 48, 64 after start, with no s_ready deassertion.
- Random s_valid/m_ready (independent 50% per cycle), 2500 random vectors of 16 elements checked against a reference model. Zero mismatches, and exactly 2500 results transferred.
